upper_reg_ctrl: RTL and testbench
=================================

Name: upper_reg_ctrl

Overview:
Sequencer for one upper-layer shift-register chain in the merge-sort stage of the KNN engine.
- Accepts TRAIN_LENGTH distance words over a valid/ready input stream.
- Drives the chain's load/shift controls to fill it, then drains it in FIFO order to the downstream merge stage over a valid/ready output stream.
- Signals completion once per batch.

Parameters:
TRAIN_LENGTH, 3, number of words per batch and depth of the controlled chain; legal range ≥1.
DATA_WIDTH, 8, width of each distance word.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a batch; honoured only in IDLE.
in_data  input  DATA_WIDTH  incoming distance word.
in_valid  input  1  in_data valid.
in_ready  output  1  controller accepts in_data this cycle.
reg_in_data  output  DATA_WIDTH  data to chain input.
reg_load  output  1  chain load control.
reg_shift  output  1  chain shift control.
reg_out  input  DATA_WIDTH  chain tail output.
out_data  output  DATA_WIDTH  word presented downstream.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts out_data.
busy  output  1  high in FILL or DRAIN.
done  output  1  one-cycle pulse after last drained word.

Behaviour:
Chain contract:
- reg_load=1 and reg_shift=1 on an edge shifts reg_in_data into the head.
- reg_shift=1 with reg_load=0 shifts zero into the head.
- reg_shift=0 holds the chain.
- The chain shares clk/reset with this block.

Reset:
- state=IDLE, cnt=0, done=0.
- All outputs 0: in_ready, reg_load, reg_shift, out_valid, busy.
- Takes effect on the next edge from any state, including mid-FILL or mid-DRAIN.
- A partially filled or partially drained batch is discarded; no done pulse.

Counter:
- cnt is $clog2(TRAIN_LENGTH+1) bits, unsigned, cleared on every state entry.

FSM:
- IDLE: in_ready=0, out_valid=0, busy=0.
  - start=1 → FILL next cycle.
  - start=0 → stay.
- FILL: busy=1, in_ready=1, out_valid=0.
  - reg_in_data=in_data (combinational).
  - reg_load=reg_shift=(in_valid & in_ready).
  - Each accepted word: cnt+1.
  - Accept with cnt==TRAIN_LENGTH-1 → DRAIN, cnt=0.
  - in_valid=0 → chain holds, cnt holds; no limit on gap length.
- DRAIN: busy=1, in_ready=0.
  - out_valid=1, out_data=reg_out (combinational).
  - reg_load=0, reg_in_data=0.
  - reg_shift=(out_valid & out_ready).
  - Each accepted word: cnt+1.
  - Accept with cnt==TRAIN_LENGTH-1 → IDLE and done=1 for exactly the next cycle.
  - out_ready=0 → chain holds, out_data stable, out_valid stays high.
- start is ignored outside IDLE; start is not queued.
- done is registered, and asserts in the first IDLE cycle.
- start in the same cycle as done=1 is accepted; FILL begins the following cycle.

Latency and throughput:
- Word order: the first accepted input word is the first output word (FIFO).
- out_valid rises one cycle after the last FILL handshake.
- One word per cycle in each direction with no bubbles under continuous valid/ready.
- Minimum batch time is 1 (start) + TRAIN_LENGTH (fill) + TRAIN_LENGTH (drain) cycles.

TRAIN_LENGTH=1:
- FILL accepts one word, then DRAIN emits one word, then done.

Data path:
- No arithmetic on data; widths pass through unchanged.
- After a full drain the chain holds all zeros.

Test Plan:
1. TRAIN_LENGTH=3, DATA_WIDTH=8; start, then in_data 5, 9, 2 on consecutive cycles with out_ready=1 → out_data 5, 9, 2 on consecutive out_valid cycles; done pulses 1 cycle after word 2; busy high for exactly 6 cycles.
2. Fill 0x11, 0x22, 0x33 with in_valid low for 2 cycles between words → reg_shift asserts only on handshake cycles; output still 0x11, 0x22, 0x33.
3. During DRAIN hold out_ready=0 for 4 cycles before the second word → out_data stays 0x22 with out_valid=1 throughout; reg_shift=0; drain resumes correctly.
4. Assert start during FILL and again during DRAIN → no effect on cnt or state; single done pulse; then start in the done cycle → in_ready=1 the following cycle.
5. Assert reset after 2 of 3 words filled → next cycle all outputs 0, state IDLE, no done; a new batch of 7, 8, 9 → outputs 7, 8, 9.
6. TRAIN_LENGTH=1; start, in_data 0xFF → out_valid next cycle with out_data 0xFF; done after one output handshake.

Source files
------------

// File: rtl/upper_reg_ctrl.sv
// upper_reg_ctrl: sequencer for one upper-layer shift-register chain
// of the KNN merge-sort stage. Fills the chain from a valid/ready
// input stream, then drains it in FIFO order to the merge stage.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle batch request (IDLE only)
//   in_data/in_valid      incoming distance word stream
//   in_ready              word accepted this cycle (FILL)
//   reg_in_data           data presented to the chain head
//   reg_load/reg_shift    chain load / shift controls
//   reg_out               chain tail output
//   out_data/out_valid    outgoing word stream (DRAIN)
//   out_ready             downstream accepts out_data
//   busy                  high in FILL or DRAIN
//   done                  one-cycle pulse after last drained word
module upper_reg_ctrl #(
    parameter int TRAIN_LENGTH = 3,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] reg_in_data,
    output logic                  reg_load,
    output logic                  reg_shift,
    input  logic [DATA_WIDTH-1:0] reg_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(TRAIN_LENGTH + 1);
    localparam logic [CW-1:0] LAST = CW'(TRAIN_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        in_ready    = 1'b0;
        reg_in_data = '0;
        reg_load    = 1'b0;
        reg_shift   = 1'b0;
        out_data    = '0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                end
            end
            FILL: begin
                busy        = 1'b1;
                in_ready    = 1'b1;
                reg_in_data = in_data;
                if (in_valid) begin
                    reg_load  = 1'b1;
                    reg_shift = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = reg_out;
                // Shifting zeros in leaves the chain cleared after
                // the last word leaves the tail.
                if (out_ready) begin
                    reg_shift = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_upper_reg_ctrl.sv
// tb_upper_reg_ctrl: self-checking bench for upper_reg_ctrl with
// behavioural shift-register chains for TRAIN_LENGTH 3 and 1.
module tb_upper_reg_ctrl;

    logic clk;
    logic reset;

    logic       start3, in_valid3, in_ready3, reg_load3, reg_shift3;
    logic       out_valid3, out_ready3, busy3, done3;
    logic [7:0] in_data3, reg_in_data3, reg_out3, out_data3;

    logic       start1, in_valid1, in_ready1, reg_load1, reg_shift1;
    logic       out_valid1, out_ready1, busy1, done1;
    logic [7:0] in_data1, reg_in_data1, reg_out1, out_data1;

    upper_reg_ctrl #(.TRAIN_LENGTH(3), .DATA_WIDTH(8)) u3 (
        .clk(clk), .reset(reset), .start(start3),
        .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .reg_in_data(reg_in_data3),
        .reg_load(reg_load3), .reg_shift(reg_shift3),
        .reg_out(reg_out3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .busy(busy3), .done(done3)
    );

    upper_reg_ctrl #(.TRAIN_LENGTH(1), .DATA_WIDTH(8)) u1 (
        .clk(clk), .reset(reset), .start(start1),
        .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .reg_in_data(reg_in_data1),
        .reg_load(reg_load1), .reg_shift(reg_shift1),
        .reg_out(reg_out1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1), .done(done1)
    );

    // Chain models: index 0 is the head, last index the tail.
    logic [7:0] ch3 [3];
    logic [7:0] ch1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) ch3[i] <= 8'h00;
            ch1 <= 8'h00;
        end else begin
            if (reg_shift3) begin
                ch3[0] <= reg_load3 ? reg_in_data3 : 8'h00;
                ch3[1] <= ch3[0];
                ch3[2] <= ch3[1];
            end
            if (reg_shift1) ch1 <= reg_load1 ? reg_in_data1 : 8'h00;
        end
    end

    assign reg_out3 = ch3[2];
    assign reg_out1 = ch1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       st;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ir;
        logic       ld;
        logic       sh;
        logic       ov;
        logic [7:0] od;
        logic       bz;
        logic       dn;
    } vec_t;

    vec_t tv [64];
    int   nv = 0;

    task automatic add(input logic st, input logic iv,
                       input logic [7:0] d, input logic ordy,
                       input logic ir, input logic ld,
                       input logic sh, input logic ov,
                       input logic [7:0] od, input logic bz,
                       input logic dn);
        tv[nv] = '{st, iv, d, ordy, ir, ld, sh, ov, od, bz, dn};
        nv++;
    endtask

    logic [7:0] src [3];

    // Reference: a batch is TRAIN_LENGTH accepted inputs followed by
    // the same words out in arrival order, then one done cycle.
    task automatic run_batch(input int pv, input int pr);
        int n_in;
        int n_out;
        int cyc;
        bit e_ir;
        bit e_ov;
        start3 = 1'b1;
        in_valid3 = 1'b0;
        out_ready3 = 1'b0;
        #4 chk("rb_idle_busy", {31'd0, busy3}, 32'd0);
        step();
        start3 = 1'b0;
        n_in = 0;
        n_out = 0;
        cyc = 0;
        while (n_out < 3 && cyc < 300) begin
            in_valid3 = (n_in < 3) &&
                        ($urandom_range(0, 99) < pv);
            in_data3 = (n_in < 3) ? src[n_in] :
                       8'($urandom_range(0, 255));
            out_ready3 = ($urandom_range(0, 99) < pr);
            e_ir = (n_in < 3);
            e_ov = (n_in == 3);
            #4;
            chk("rb_in_ready", {31'd0, in_ready3}, {31'd0, e_ir});
            chk("rb_out_valid", {31'd0, out_valid3},
                {31'd0, e_ov});
            chk("rb_busy", {31'd0, busy3}, 32'd1);
            if (e_ov)
                chk("rb_out_data", {24'd0, out_data3},
                    {24'd0, src[n_out]});
            if (e_ir && in_valid3) n_in++;
            if (e_ov && out_ready3) n_out++;
            step();
            cyc++;
        end
        if (n_out < 3) chk("rb_timeout", 32'd0, 32'd1);
        in_valid3 = 1'b0;
        out_ready3 = 1'b0;
        #4;
        chk("rb_done", {30'd0, done3, busy3}, 32'd2);
        chk("rb_chain_zero", {8'd0, ch3[0], ch3[1], ch3[2]}, 32'd0);
        step();
        #4 chk("rb_done_once", {31'd0, done3}, 32'd0);
        step();
    endtask

    initial begin
        logic [31:0] act;
        logic [31:0] exp;
        logic [7:0]  rid;

        reset = 1'b1;
        start3 = 1'b0; in_valid3 = 1'b0; in_data3 = 8'h00;
        out_ready3 = 1'b0;
        start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00;
        out_ready1 = 1'b0;
        step();
        step();
        #4;
        chk("reset_outs3",
            {23'd0, in_ready3, reg_load3, reg_shift3, out_valid3,
             busy3, done3, 3'd0},
            32'd0);
        chk("reset_outs1",
            {26'd0, in_ready1, reg_load1, reg_shift1, out_valid1,
             busy1, done1},
            32'd0);
        step();
        reset = 1'b0;

        // Basic 5,9,2 batch.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'h05, 1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 8'h09, 1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 8'h02, 1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h05, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h09, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h02, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1);
        // Input gaps.
        add(1, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'h11, 1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 1, 8'h22, 1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 1, 8'h33, 1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h11, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h22, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h33, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1);
        // Output backpressure before the second word.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'h11, 0, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 8'h22, 0, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 8'h33, 0, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h11, 1, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h22, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h22, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h33, 1, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        // start outside IDLE ignored; start in done cycle accepted.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h41, 0, 1, 1, 1, 0, 8'h00, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 1, 8'h42, 0, 1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 1, 8'h43, 0, 1, 1, 1, 0, 8'h00, 1, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 8'h41, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h41, 1, 0);
        add(1, 0, 8'h00, 1, 0, 0, 1, 1, 8'h42, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h43, 1, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 1, 0);

        for (int i = 0; i < nv; i++) begin
            start3 = tv[i].st;
            in_valid3 = tv[i].iv;
            in_data3 = tv[i].d;
            out_ready3 = tv[i].ordy;
            rid = tv[i].ir ? tv[i].d : 8'h00;
            exp = {tv[i].ir, tv[i].ld, tv[i].sh, tv[i].ov,
                   tv[i].bz, tv[i].dn, 2'b00, tv[i].od, rid, 8'h00};
            #4;
            act = {in_ready3, reg_load3, reg_shift3, out_valid3,
                   busy3, done3, 2'b00, out_data3, reg_in_data3,
                   8'h00};
            if (act !== exp) begin
                n_tests++;
                n_fail++;
                $display("FAIL vec%0d: got %h expected %h", i, act,
                         exp);
            end else begin
                n_tests++;
            end
            step();
        end

        // Leave the batch opened by the last vector via reset.
        start3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Reset after two of three words filled.
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        in_valid3 = 1'b1;
        in_data3 = 8'h01;
        step();
        in_data3 = 8'h02;
        step();
        reset = 1'b1;
        in_data3 = 8'h03;
        step();
        reset = 1'b0;
        in_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("rst_mid_fill",
                {26'd0, in_ready3, reg_load3, reg_shift3,
                 out_valid3, busy3, done3},
                32'd0);
            step();
        end
        src[0] = 8'h07; src[1] = 8'h08; src[2] = 8'h09;
        run_batch(100, 100);

        // TRAIN_LENGTH=1 instance.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        in_valid1 = 1'b1;
        in_data1 = 8'hFF;
        #4;
        chk("tl1_fill",
            {21'd0, in_ready1, reg_load1, reg_shift1, out_valid1,
             reg_in_data1},
            {21'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF});
        step();
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        #4;
        chk("tl1_drain",
            {22'd0, in_ready1, out_valid1, out_data1},
            {22'd0, 1'b0, 1'b1, 8'hFF});
        step();
        out_ready1 = 1'b0;
        #4;
        chk("tl1_done",
            {23'd0, done1, busy1, reg_out1},
            {23'd0, 1'b1, 1'b0, 8'h00});
        step();
        #4 chk("tl1_done_once", {31'd0, done1}, 32'd0);
        step();

        // Randomized batches on the depth-3 chain.
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 3; k++)
                src[k] = 8'($urandom_range(0, 255));
            run_batch($urandom_range(30, 100),
                      $urandom_range(30, 100));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
